// File: rtl/gf163_reduce.sv
// gf163_reduce
// Reduces the unreduced 326-bit product of the 163x163 GF(2) multiplier
// modulo f(x) = x^163 + x^7 + x^6 + x^3 + 1. The work is done in two folds:
// the first is registered and the second is combinational in front of an
// output FIFO.
//
// The multiplier upstream cannot stall. To make that safe, this block only
// lets a multiply launch when it already holds FIFO space for the result.
// It does this with a credit counter.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   issue_valid  in   upstream launches a multiply this cycle
//   issue_ready  out  credit available; launch counts only with issue_valid
//   d[325:0]     in   unreduced product, sampled MULT_LAT cycles after launch
//   res_valid    out  FIFO head valid
//   res_ready    in   consumer takes the head
//   res[162:0]   out  reduced result (zero while the FIFO is empty)
//   busy         out  at least one operation outstanding
//   overflow_err out  sticky: launch attempted without a credit
module gf163_reduce #(
  parameter int MULT_LAT = 2,
  parameter int DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  logic [325:0] d,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [162:0] res,
  output logic         busy,
  output logic         overflow_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]       credit;
  logic                accept;
  logic                pop;
  logic [MULT_LAT-1:0] tag;
  logic                s0_valid;
  logic [162:0]        hi;
  logic [169:0]        s1_next;
  logic [169:0]        r1;
  logic                v1;
  logic [6:0]          h2;
  logic [162:0]        r;
  logic [162:0]        mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_count;

  assign issue_ready = (credit < CW'(DEPTH));
  assign accept      = issue_valid && issue_ready;
  assign res_valid   = (fifo_count != '0);
  assign pop         = res_valid && res_ready;
  assign busy        = (credit != '0);
  assign s0_valid    = tag[MULT_LAT-1];

  // A tag travels alongside each launched multiply. When the tag reaches the
  // end of this shift register, the product on d belongs to that launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag <= '0;
    end else begin
      tag[0] <= accept;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  // First fold: x^163 == x^7 + x^6 + x^3 + 1. The upper half is therefore
  // folded down with four shifted copies. This leaves up to 7 bits above
  // x^162.
  assign hi      = d[325:163];
  assign s1_next = {7'b0, d[162:0]} ^ {7'b0, hi} ^ ({7'b0, hi} << 3)
                 ^ ({7'b0, hi} << 6) ^ ({7'b0, hi} << 7);

  always_ff @(posedge clk) begin
    if (s0_valid) begin
      r1 <= s1_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
    end else begin
      v1 <= s0_valid;
    end
  end

  // Second fold: h2 has degree <= 6, so the folded terms reach degree 13 at
  // most. The result is fully reduced after this step.
  assign h2 = r1[169:163];
  assign r  = r1[162:0] ^ {156'b0, h2} ^ ({156'b0, h2} << 3)
            ^ ({156'b0, h2} << 6) ^ ({156'b0, h2} << 7);

  // FIFO storage carries no reset. Only the pointers and count decide what
  // is visible.
  always_ff @(posedge clk) begin
    if (v1) begin
      mem[wr_ptr] <= r;
    end
  end

  // Pointers wrap modulo DEPTH. The count tracks occupancy and supports
  // simultaneous push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (v1) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({v1, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A credit is held from launch until the result is consumed. This bounds
  // the number of products in flight to the FIFO capacity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  // A launch attempt without a credit cannot be honoured. It is flagged
  // until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (issue_valid && !issue_ready) begin
      overflow_err <= 1'b1;
    end
  end

  assign res = res_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_gf163_reduce.sv
// tb_gf163_reduce
// Directed bench for gf163_reduce.
//
// A queue-based model tracks each accepted launch. For every launch it
// records the reduced value and the cycle from which the result should be
// visible. The reduced value comes from polynomial long division by f(x).
// Outstanding credits are simply the queue length.
//
// Every cycle, the DUT outputs are compared against this model. A few
// literal expectations pin the model and the directed cases.
module tb_gf163_reduce;

  localparam int MULT_LAT = 2;
  localparam int DEPTH    = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         issue_valid = 1'b0;
  logic         issue_ready;
  logic [325:0] d = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [162:0] res;
  logic         busy;
  logic         overflow_err;

  gf163_reduce #(.MULT_LAT(MULT_LAT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .d            (d),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res          (res),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [162:0] val;
    int           rdy;
  } item_t;

  item_t        q[$];
  logic [325:0] d_sched [int];
  logic [325:0] issue_data = '0;
  logic         ovf_m = 1'b0;
  bit           pop_m;
  bit           acc_m;
  bit           exp_valid;
  int           cyc = 0;
  int           n_acc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  // Long division by f(x) = x^163 + x^7 + x^6 + x^3 + 1.
  function automatic logic [162:0] ref_reduce(input logic [325:0] p);
    logic [325:0] t;
    logic [325:0] f;
    t = p;
    f = (326'd1 << 163) | 326'hC9;
    for (int i = 325; i >= 163; i--) begin
      if (t[i]) t = t ^ (f << (i - 163));
    end
    return t[162:0];
  endfunction

  function automatic logic [325:0] rand326();
    logic [325:0] v;
    v = '0;
    for (int i = 0; i < 11; i++) v = (v << 32) | 326'($urandom);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [325:0] actual,
                             input logic [325:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                  name, cyc, actual, expected);
  endtask

  task automatic applyStimulus(input logic iv, input logic [325:0] val,
                               input logic rr);
    @(negedge clk);
    issue_valid = iv;
    issue_data  = val;
    res_ready   = rr;
  endtask

  // Launch only while the model says a credit exists, so streaming
  // never trips overflow.
  task automatic streamStep(input logic rr);
    @(negedge clk);
    if (q.size() < DEPTH) begin
      issue_valid = 1'b1;
      issue_data  = rand326();
    end else begin
      issue_valid = 1'b0;
    end
    res_ready = rr;
  endtask

  // Model clock edge: acceptance uses the credit state before this edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      d_sched.delete();
      ovf_m = 1'b0;
    end else begin
      pop_m = (q.size() > 0) && (q[0].rdy <= cyc) && res_ready;
      acc_m = issue_valid && (q.size() < DEPTH);
      if (issue_valid && !(q.size() < DEPTH)) ovf_m = 1'b1;
      if (pop_m) void'(q.pop_front());
      if (acc_m) begin
        q.push_back(item_t'{ref_reduce(issue_data), cyc + MULT_LAT + 2});
        d_sched[cyc + MULT_LAT] = issue_data;
        n_acc++;
      end
    end
    cyc++;
  end

  always @(posedge rst) begin
    q.delete();
    d_sched.delete();
    ovf_m = 1'b0;
  end

  // The product appears on d only in its scheduled cycle; otherwise d
  // carries noise that must be ignored.
  always @(negedge clk) begin
    if (d_sched.exists(cyc)) begin
      d = d_sched[cyc];
      d_sched.delete(cyc);
    end else begin
      d = rand326();
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    #2;
    exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
    checkOutput("res_valid", res_valid, exp_valid);
    if (exp_valid) checkOutput("res", res, q[0].val);
    checkOutput("issue_ready", issue_ready, q.size() < DEPTH);
    checkOutput("busy", busy, q.size() != 0);
    checkOutput("overflow_err", overflow_err, ovf_m);
  end

  initial begin
    int start;
    int guard;
    int step;

    $display("[TB] start");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_res", res, 163'h0);
    checkOutput("rst_issue_ready", issue_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_overflow", overflow_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Hand-computed values that pin the reference model.
    checkOutput("model_one", ref_reduce(326'h1), 163'h1);
    checkOutput("model_fold1", ref_reduce(326'd1 << 163), 163'hC9);
    checkOutput("model_fold2", ref_reduce(326'd1 << 324),
                (163'd1 << 161) | 163'h1422);

    // Pass-through: visible exactly MULT_LAT+2 cycles after launch.
    applyStimulus(1'b1, 326'h1, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("pt_valid", res_valid, 1'b1);
    checkOutput("pt_res", res, 163'h1);
    applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("pt_valid_after", res_valid, 1'b0);
    checkOutput("pt_busy_after", busy, 1'b0);

    // Single fold.
    applyStimulus(1'b1, 326'd1 << 163, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("fold1_valid", res_valid, 1'b1);
    checkOutput("fold1_res", res, 163'hC9);
    applyStimulus(1'b0, '0, 1'b1);

    // Double fold, including the intermediate carry-out of the first fold.
    applyStimulus(1'b1, 326'd1 << 324, 1'b1);
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("fold2_v1", dut.v1, 1'b1);
    checkOutput("fold2_h2", dut.h2, 7'b0110010);
    applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("fold2_res", res, (163'd1 << 161) | 163'h1422);
    applyStimulus(1'b0, '0, 1'b1);

    // Backpressure: four launches take every credit, and the fifth is
    // refused.
    repeat (5) applyStimulus(1'b1, rand326(), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    #1;
    checkOutput("bp_issue_ready", issue_ready, 1'b0);
    checkOutput("bp_overflow", overflow_err, 1'b1);
    repeat (6) applyStimulus(1'b0, '0, 1'b1);

    // Streaming with the consumer always ready.
    start = n_acc;
    guard = 0;
    while ((n_acc - start) < 32 && guard < 300) begin
      streamStep(1'b1);
      guard++;
    end
    if (guard >= 300) checkOutput("stream_timeout", n_acc - start, 32);
    repeat (8) applyStimulus(1'b0, '0, 1'b1);

    // Streaming with the consumer stalling every third cycle.
    start = n_acc;
    guard = 0;
    step  = 0;
    while ((n_acc - start) < 32 && guard < 300) begin
      streamStep((step % 3) != 2);
      step++;
      guard++;
    end
    if (guard >= 300) checkOutput("stall_timeout", n_acc - start, 32);
    repeat (10) applyStimulus(1'b0, '0, 1'b1);

    // Reset with one result in the FIFO, one in stage 1 and one on the
    // tag line.
    applyStimulus(1'b1, rand326(), 1'b0);
    applyStimulus(1'b1, rand326(), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, rand326(), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    issue_valid = 1'b0;
    #1;
    checkOutput("midrst_res_valid", res_valid, 1'b0);
    checkOutput("midrst_issue_ready", issue_ready, 1'b1);
    checkOutput("midrst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("stale_res_valid", res_valid, 1'b0);
    checkOutput("stale_busy", busy, 1'b0);
    checkOutput("stale_overflow", overflow_err, 1'b0);

    // The block still works after the reset.
    applyStimulus(1'b1, rand326(), 1'b1);
    repeat (6) applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gf163_reduce.md
Name: gf163_reduce

Overview:
Downstream stage of the 163x163 GF(2) polynomial multiplier. It takes the unreduced 326-bit product and reduces it modulo f(x) = x^163 + x^7 + x^6 + x^3 + 1 through a two-stage fold pipeline. Results are buffered in an output FIFO with valid/ready. The multiplier cannot stall, so the block grants issue credits upstream and never loses a product in flight.

Parameters:
MULT_LAT, 2, cycles from an accepted issue to its product being valid on d
DEPTH, 4, output FIFO entries and maximum outstanding operations; must be >= 1; full throughput requires DEPTH >= MULT_LAT+2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
issue_valid  input  1  upstream launches a multiply this cycle
issue_ready  output  1  credit available; a launch counts only when issue_valid && issue_ready
d  input  326  unreduced product, sampled exactly MULT_LAT cycles after the accepted issue
res_valid  output  1  FIFO head valid
res_ready  input  1  consumer accepts the head
res  output  163  reduced result, degree <= 162
busy  output  1  any operation outstanding
overflow_err  output  1  sticky: issue_valid seen while issue_ready == 0

Behaviour:
- Reset (async, rst=1): clears the tag delay line, stage valids, FIFO pointers/count and credit counter.
  - Outputs during/after reset: res_valid=0, res=0, issue_ready=1, busy=0, overflow_err=0.
  - Reset mid-operation discards all in-flight products.
- Tag delay line: MULT_LAT-bit shift register; bit 0 is loaded with issue_valid && issue_ready.
  - The tag emerging at the end marks d as valid in that cycle (s0_valid).
- Stage 1 (registered on s0_valid):
  - hi = d[325:163].
  - r1[169:0] = d[162:0] ^ hi ^ (hi<<3) ^ (hi<<6) ^ (hi<<7).
  - v1 <= s0_valid.
- Stage 2 (combinational from r1, written into FIFO when v1):
  - h2 = r1[169:163].
  - r = r1[162:0] ^ h2 ^ (h2<<3) ^ (h2<<6) ^ (h2<<7).
  - Maximum h2 term degree is 13, so r is fully reduced.
- Latency: issue accepted at cycle T -> res_valid earliest at T+MULT_LAT+2 (FIFO first-word fall-through, registered storage).
- Throughput: one result per cycle when res_ready is held high and DEPTH >= MULT_LAT+2.
- Credit counter (0..DEPTH):
  - +1 on an accepted issue, -1 on res_valid && res_ready; both in the same cycle -> unchanged.
  - issue_ready = (count < DEPTH).
  - Guarantees the FIFO never overflows, since outstanding products = count.
- FIFO:
  - Write on v1, read on res_valid && res_ready; simultaneous read and write when full is impossible by credit.
  - Simultaneous read and write when count==1 keeps order.
  - Pointers wrap modulo DEPTH.
  - res holds its value while res_valid && !res_ready.
- Issue handling:
  - issue_valid while !issue_ready: ignored (no tag, no credit) and sets overflow_err until reset.
  - d is ignored in cycles with no emerging tag.
- busy = (count != 0).
- Ordering: results leave in issue order. No reordering, no drops.

Test Plan:
- Pass-through: issue, d = 326'h1 -> res = 163'h1 at T+MULT_LAT+2, res_valid for one cycle with res_ready=1; busy returns to 0.
- Single fold: d = 1<<163 -> res = 163'hC9.
- Double fold: d = 1<<324 -> res = (1<<161) | 163'h1422; check h2 = 7'b0110010 internally.
- Backpressure/credits: res_ready=0, DEPTH=4, issue every cycle -> exactly 4 accepted, issue_ready=0 thereafter, 5th issue sets overflow_err.
  - Then res_ready=1 -> 4 results in issue order, one per cycle, issue_ready re-asserts the cycle after the first pop.
- Streaming: res_ready=1, 32 back-to-back random products -> 32 results match a software model with zero bubbles.
  - Pulse res_ready=0 every 3rd cycle -> no loss or duplication.
- Reset mid-operation: assert rst with 3 outstanding (one in FIFO, one in stage 1, one in the delay line) -> res_valid=0 immediately, count=0, issue_ready=1.
  - A stale d after reset produces no result.
